// File: rtl/float16_add_scheduler.sv
// float16_add_scheduler: round-robin sharing of one pipelined float16 adder among
// NUM_REQ requesters, with one held response slot per requester.
module float16_add_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int FLOAT_LEN = 16,
    parameter int ADD_LAT   = 2,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*FLOAT_LEN-1:0] req_a,
    input  logic [NUM_REQ*FLOAT_LEN-1:0] req_b,
    output logic [FLOAT_LEN-1:0]         add_a,
    output logic [FLOAT_LEN-1:0]         add_b,
    input  logic [FLOAT_LEN-1:0]         add_result,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUM_REQ*FLOAT_LEN-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic                         idle
);

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   inflight_q, inflight_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [FLOAT_LEN-1:0] rsp_data_q [NUM_REQ];
    logic [FLOAT_LEN-1:0] rsp_data_d [NUM_REQ];
    logic                 idle_q, idle_d;

    logic [ADD_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]      tag_id_q [ADD_LAT];
    logic [ID_W-1:0]      tag_id_d [ADD_LAT];

    logic [NUM_REQ-1:0]   elig;
    logic [NUM_REQ-1:0]   grant_oh;
    logic [NUM_REQ-1:0]   cap_oh;
    logic                 grant_vld;
    logic [ID_W-1:0]      grant_id;
    logic                 cap_vld;
    logic [ID_W-1:0]      cap_id;
    int                   scan_idx;

    // A requester with an op in the adder or an unaccepted response must wait,
    // since the adder cannot be stalled to protect an occupied slot.
    assign elig = req_valid & ~inflight_q & ~rsp_valid_q;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            scan_idx = int'(rr_ptr_q) + off;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!grant_vld && elig[scan_idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    assign cap_vld = tag_vld_q[ADD_LAT-1];
    assign cap_id  = tag_id_q[ADD_LAT-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign grant_oh[gi] = grant_vld && (grant_id == ID_W'(gi));
            assign cap_oh[gi]   = cap_vld && (cap_id == ID_W'(gi));
            assign rsp_data[gi*FLOAT_LEN +: FLOAT_LEN] = rsp_data_q[gi];
        end
    endgenerate

    assign req_ready = grant_oh;
    assign rsp_valid = rsp_valid_q;
    assign idle      = idle_q;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            add_a = add_a | (req_a[i*FLOAT_LEN +: FLOAT_LEN] & {FLOAT_LEN{grant_oh[i]}});
            add_b = add_b | (req_b[i*FLOAT_LEN +: FLOAT_LEN] & {FLOAT_LEN{grant_oh[i]}});
        end
    end

    // Tag pipe: stage 0 takes the grant, the tail lines up with add_result.
    generate
        for (gi = 0; gi < ADD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_vld_d[gi] = grant_vld;
                assign tag_id_d[gi]  = grant_id;
            end else begin : g_shift
                assign tag_vld_d[gi] = tag_vld_q[gi-1];
                assign tag_id_d[gi]  = tag_id_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        inflight_d  = inflight_q;
        rsp_valid_d = rsp_valid_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data_d[i] = rsp_data_q[i];
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
            if (cap_oh[i]) begin
                inflight_d[i]  = 1'b0;
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = add_result;
            end
            if (grant_oh[i]) begin
                inflight_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    // idle reflects the state registered at the same edge, not one cycle later.
    assign idle_d = ~|inflight_d & ~|rsp_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            inflight_q  <= '0;
            rsp_valid_q <= '0;
            idle_q      <= 1'b1;
            tag_vld_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_data_q[i] <= '0;
            end
            for (int s = 0; s < ADD_LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            rsp_valid_q <= rsp_valid_d;
            idle_q      <= idle_d;
            tag_vld_q   <= tag_vld_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_data_q[i] <= rsp_data_d[i];
            end
            for (int s = 0; s < ADD_LAT; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    // A returning sum must never land on a slot still holding a response.
    a_no_slot_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
        !(cap_vld && |(cap_oh & rsp_valid_q)));

endmodule

// File: tb/tb_float16_add_scheduler.sv
// Directed and model-checked bench for float16_add_scheduler with a two-stage
// stand-in adder whose sums for the directed vectors are hand-computed constants.
module tb_float16_add_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int FLOAT_LEN = 16;
    localparam int ADD_LAT   = 2;
    localparam int ID_W      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic [15:0] add_a, add_b, add_result;
    logic [3:0]  rsp_valid;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_ready = '0;
    logic        idle;

    integer checks = 0;
    integer failures = 0;

    always #5 clk = ~clk;

    float16_add_scheduler #(
        .NUM_REQ(NUM_REQ), .FLOAT_LEN(FLOAT_LEN), .ADD_LAT(ADD_LAT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .idle(idle)
    );

    // Stand-in adder: directed pairs give true float16 sums; any other pair gives
    // a fixed scramble, which is enough because the scheduler never alters data.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_3C00: return 16'h4000;
            32'h4000_4200: return 16'h4500;
            32'h7C00_FC00: return 16'h7E00;
            32'h7C00_3C00: return 16'h7C00;
            default:       return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
        endcase
    endfunction

    logic [15:0] add_s1, add_s2;
    always @(posedge clk) begin
        add_s1 <= ref_add(add_a, add_b);
        add_s2 <= add_s1;
    end
    assign add_result = add_s2;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++;
        if (rsp_data !== 64'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
        do_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++;
        if ({add_a, add_b} !== 32'h0) begin failures++; $display("FAIL reset_add_ops got=%h exp=0", {add_a, add_b}); end
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL post_reset_idle got=%b exp=1", idle); end
        $display("txn reset done");
    endtask

    task automatic test_single_op();
        do_reset();
        set_op(0, 16'h3C00, 16'h3C00);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
        checks++;
        if ({add_a, add_b} !== 32'h3C00_3C00) begin failures++; $display("FAIL single_add_ops got=%h exp=3c003c00", {add_a, add_b}); end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL single_idle_n1 got=%b exp=0", idle); end
        checks++;
        if (add_a !== 16'h0) begin failures++; $display("FAIL single_add_a_nogrant got=%h exp=0000", add_a); end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_early got=%b exp=0000", rsp_valid); end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid_n3 got=%b exp=0001", rsp_valid); end
        checks++;
        if (rsp_data[15:0] !== 16'h4000) begin failures++; $display("FAIL single_rsp_data got=%h exp=4000", rsp_data[15:0]); end
        step();
        rsp_ready = 4'b0001;
        @(negedge clk);
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL single_idle_hs got=%b exp=0", idle); end
        step();
        rsp_ready = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_clear got=%b exp=0000", rsp_valid); end
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL single_idle_end got=%b exp=1", idle); end
        checks++;
        if (rsp_data[15:0] !== 16'h4000) begin failures++; $display("FAIL single_data_hold got=%h exp=4000", rsp_data[15:0]); end
        $display("txn single req0 sum=%h", rsp_data[15:0]);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy [8];
        logic [3:0] exp_rsp [8];
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp_rsp = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 16'h4000, 16'h4200);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== exp_rdy[c]) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy[c]); end
            checks++;
            if (rsp_valid !== exp_rsp[c]) begin failures++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp[c]); end
            step();
        end
        rsp_ready = 4'b1111;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_data !== 64'h4500_4500_4500_4500) begin failures++; $display("FAIL rr_rsp_data got=%h exp=4500450045004500", rsp_data); end
        step();
        rsp_ready = '0;
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rr_rsp_clear got=%b exp=0000", rsp_valid); end
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL rr_ptr_wrap got=%b exp=0001", req_ready); end
        #1 req_valid = '0;
        step();
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL rr_idle_nogrant got=%b exp=1", idle); end
        $display("txn round_robin 4 ops sum=4500");
    endtask

    task automatic test_special();
        do_reset();
        set_op(2, 16'h7C00, 16'hFC00);
        set_op(3, 16'h7C00, 16'h3C00);
        req_valid = 4'b1100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL special_grant2 got=%b exp=0100", req_ready); end
        checks++;
        if ({add_a, add_b} !== 32'h7C00_FC00) begin failures++; $display("FAIL special_ops2 got=%h exp=7c00fc00", {add_a, add_b}); end
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL special_grant3 got=%b exp=1000", req_ready); end
        step();
        req_valid = '0;
        @(negedge clk);
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL special_rsp2_valid got=%b exp=0100", rsp_valid); end
        checks++;
        if (rsp_data[47:32] !== 16'h7E00) begin failures++; $display("FAIL special_inf_minus_inf got=%h exp=7e00", rsp_data[47:32]); end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b1100) begin failures++; $display("FAIL special_rsp3_valid got=%b exp=1100", rsp_valid); end
        checks++;
        if (rsp_data[63:48] !== 16'h7C00) begin failures++; $display("FAIL special_inf_plus_one got=%h exp=7c00", rsp_data[63:48]); end
        step();
        rsp_ready = 4'b1100;
        step();
        rsp_ready = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL special_clear got=%b exp=0000", rsp_valid); end
        $display("txn special req2=%h req3=%h", rsp_data[47:32], rsp_data[63:48]);
    endtask

    task automatic test_backpressure();
        int gcnt [4];
        gcnt = '{0, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 16'h4000, 16'h4200);
        set_op(1, 16'h3C00, 16'h3C00);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        req_valid = 4'b1111;
        rsp_ready = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_req1_blocked c=%0d got=%b exp=0", c, req_ready[1]); end
            checks++;
            if (rsp_valid[1] !== 1'b1) begin failures++; $display("FAIL bp_rsp1_held c=%0d got=%b exp=1", c, rsp_valid[1]); end
            for (int i = 0; i < 4; i++) if (req_ready[i]) gcnt[i]++;
            step();
        end
        checks++;
        if (gcnt[0] < 4 || gcnt[2] < 4 || gcnt[3] < 4) begin
            failures++;
            $display("FAIL bp_others_granted got=%0d/%0d/%0d exp=each>=4", gcnt[0], gcnt[2], gcnt[3]);
        end
        rsp_ready = 4'b1111;
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (rsp_data[31:16] !== 16'h4000) begin failures++; $display("FAIL bp_rsp1_data got=%h exp=4000", rsp_data[31:16]); end
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid[1] !== 1'b0) begin failures++; $display("FAIL bp_rsp1_clear got=%b exp=0", rsp_valid[1]); end
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_regrant got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        repeat (6) step();
        rsp_ready = '0;
        $display("txn backpressure grants r0=%0d r2=%0d r3=%0d", gcnt[0], gcnt[2], gcnt[3]);
    endtask

    task automatic test_fairness();
        do_reset();
        set_op(1, 16'h4000, 16'h4200);
        set_op(3, 16'h3C00, 16'h3C00);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL fair_setup got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        rsp_ready = 4'b1111;
        repeat (3) step();
        req_valid = 4'b1010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL fair_first got=%b exp=1000", req_ready); end
        step();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL fair_second got=%b exp=0010", req_ready); end
        step();
        req_valid = '0;
        repeat (6) step();
        rsp_ready = '0;
        $display("txn fairness order 3 then 1");
    endtask

    task automatic test_random();
        int          m_ptr;
        logic [3:0]  m_inflight, m_rspv, n_rspv, elig, exp_g;
        logic [15:0] m_data [4];
        logic        m_tag_v [2];
        int          m_tag_id [2];
        logic [15:0] m_tag_d [2];
        logic        m_idle;
        int          gid, idx;
        int          outst [4];
        logic [15:0] exp_a;
        do_reset();
        m_ptr = 0; m_inflight = '0; m_rspv = '0; m_idle = 1'b1;
        m_tag_v = '{1'b0, 1'b0}; m_tag_id = '{0, 0}; m_tag_d = '{16'h0, 16'h0};
        m_data = '{16'h0, 16'h0, 16'h0, 16'h0};
        outst = '{0, 0, 0, 0};
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rsp_ready[i] = $urandom_range(0, 1) == 1;
            end
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            @(negedge clk);
            elig = req_valid & ~m_inflight & ~m_rspv;
            exp_g = '0; gid = 0;
            for (int off = 0; off < 4; off++) begin
                idx = (m_ptr + off) % 4;
                if (exp_g == 0 && elig[idx]) begin exp_g[idx] = 1'b1; gid = idx; end
            end
            exp_a = (exp_g != 0) ? req_a[gid*16 +: 16] : 16'h0;
            checks++;
            if (req_ready !== exp_g) begin failures++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, req_ready, exp_g); end
            checks++;
            if (add_a !== exp_a) begin failures++; $display("FAIL rand_add_a c=%0d got=%h exp=%h", c, add_a, exp_a); end
            checks++;
            if (rsp_valid !== m_rspv) begin failures++; $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, m_rspv); end
            checks++;
            if (idle !== m_idle) begin failures++; $display("FAIL rand_idle c=%0d got=%b exp=%b", c, idle, m_idle); end
            for (int i = 0; i < 4; i++) begin
                if (m_rspv[i]) begin
                    checks++;
                    if (rsp_data[i*16 +: 16] !== m_data[i]) begin
                        failures++;
                        $display("FAIL rand_rsp_data c=%0d req=%0d got=%h exp=%h", c, i, rsp_data[i*16 +: 16], m_data[i]);
                    end
                end
                if (req_ready[i] === 1'b1) outst[i]++;
                if (rsp_valid[i] === 1'b1 && rsp_ready[i]) outst[i]--;
                checks++;
                if (outst[i] > 1) begin failures++; $display("FAIL rand_outstanding c=%0d req=%0d got=%0d exp<=1", c, i, outst[i]); end
            end
            n_rspv = m_rspv & ~rsp_ready;
            if (m_tag_v[1]) begin
                n_rspv[m_tag_id[1]] = 1'b1;
                m_data[m_tag_id[1]] = m_tag_d[1];
                m_inflight[m_tag_id[1]] = 1'b0;
            end
            if (exp_g != 0) begin
                m_inflight[gid] = 1'b1;
                m_ptr = (gid + 1) % 4;
            end
            m_rspv = n_rspv;
            m_tag_v[1] = m_tag_v[0]; m_tag_id[1] = m_tag_id[0]; m_tag_d[1] = m_tag_d[0];
            m_tag_v[0] = (exp_g != 0); m_tag_id[0] = gid;
            m_tag_d[0] = ref_add(req_a[gid*16 +: 16], req_b[gid*16 +: 16]);
            m_idle = (m_inflight == 0) && (m_rspv == 0);
            step();
        end
        req_valid = '0;
        rsp_ready = '0;
        $display("txn random 10000 cycles checked");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_op(0, 16'h3C00, 16'h3C00);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle_in_reset got=%b exp=1", idle); end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL mid_spurious_rsp c=%0d got=%b exp=0000", c, rsp_valid); end
            checks++;
            if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle c=%0d got=%b exp=1", c, idle); end
        end
        $display("txn reset_midflight no response");
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_special();
        test_backpressure();
        test_fairness();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
